box_motion_ctrl: RTL
====================

BOX_MOTION_CTRL -- requirements
Module: box_motion_ctrl

Interface
REQ-001 Parameter SCREEN_W, default 800, active display width in pixels.
REQ-002 Parameter SCREEN_H, default 480, active display height in lines.
REQ-003 Parameter BOX_W, default 70, box width; BOX_H, default 70, box height.
REQ-004 Parameter DEBOUNCE_CYC, default 250000, number of clk cycles a button level must stay stable before it is accepted.
REQ-005 Parameter SPEED_MAX, default 7, maximum pixels moved per frame.
REQ-006 clk  input  1  system clock.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 vsync  input  1  timing-generator VSYNC, asynchronous to clk domain logic; high = blanking.
REQ-009 btn_pause_n  input  1  pause/resume button, active-low, asynchronous, bouncing.
REQ-010 btn_speed_n  input  1  speed-step button, active-low, asynchronous, bouncing.
REQ-011 box_x  output  10  box left edge, 0..SCREEN_W-BOX_W.
REQ-012 box_y  output  9  box top edge, 0..SCREEN_H-BOX_H.
REQ-013 dir_x  output  1  0 = moving right, 1 = moving left; dir_y  output  1  0 = down, 1 = up.
REQ-014 speed  output  3  current step size, 1..SPEED_MAX.
REQ-015 running  output  1  high in state RUN.
REQ-016 hit  output  1  one-cycle pulse on any wall bounce; hit_corner  output  1  one-cycle pulse when both axes bounce on the same update.

Function
REQ-017 vsync SHALL pass through a 2-FF synchronizer; frame_tick SHALL be the rising edge of the synchronized signal, one cycle wide.
REQ-018 Position registers SHALL update on the clk edge where frame_tick is high, so box_x/box_y change on the 3rd clk edge after vsync is first sampled high, which is inside blanking.
REQ-019 box_x, box_y, dir_x, dir_y, hit and hit_corner SHALL update on the same edge, so consumers never see a mixed old/new position.
REQ-020 FSM states: INIT, RUN, PAUSE.
REQ-021 INIT -> RUN on the first frame_tick; that tick SHALL NOT move the box.
REQ-022 RUN -> PAUSE and PAUSE -> RUN SHALL happen on an accepted pause press; INIT SHALL ignore pause presses.
REQ-023 Position SHALL move only on frame_tick while in RUN.
REQ-024 X, dir_x=0: if box_x+speed >= SCREEN_W-BOX_W, box_x <= SCREEN_W-BOX_W, dir_x <= 1 and hit is pulsed; otherwise box_x <= box_x+speed.
REQ-025 X, dir_x=1: if box_x <= speed, box_x <= 0, dir_x <= 0 and hit is pulsed; otherwise box_x <= box_x-speed.
REQ-026 The Y axis SHALL follow the same rules with SCREEN_H/BOX_H and dir_y; arithmetic is unsigned, computed 1 bit wider, and never wraps.
REQ-027 If both axes bounce on one update, hit and hit_corner SHALL pulse together, once.
REQ-028 Each button SHALL use a 2-FF synchronizer, then a debounce counter that clears whenever the synced level differs from the accepted level; the accepted level SHALL take the synced level when the counter reaches DEBOUNCE_CYC-1.
REQ-029 A press SHALL be an accepted-level 1->0 transition; its action SHALL take effect on the next clk edge; holding the button SHALL produce exactly one action.
REQ-030 A speed press SHALL set speed to speed+1, or to 1 when speed = SPEED_MAX; it SHALL act in any state.
REQ-031 A pause press and a frame_tick on the same cycle SHALL apply the position update using the pre-press state; the state change then follows.
REQ-032 A speed change coinciding with frame_tick SHALL NOT affect that frame's step.

Reset
REQ-033 While rst=0: state INIT, box_x=2, box_y=2, dir_x=0, dir_y=0, speed=1, running=0, hit=0, hit_corner=0, synchronizers and accepted button levels=1, debounce counters=0.
REQ-034 Reset asserted mid-frame or mid-debounce SHALL take effect immediately; after release, the first frame_tick only moves INIT -> RUN.

Verification (bench uses DEBOUNCE_CYC=4)
REQ-035 Reset, then 3 vsync pulses -> 1st pulse: state RUN, box stays (2,2); 2nd pulse: (3,3); 3rd pulse: (4,4); each change lands 3 clk after vsync rises.
REQ-036 box_x=729, dir_x=0, speed=2, frame -> box_x=730, dir_x=1, hit pulses 1 cycle; next frame -> 728.
REQ-037 box=(1,1), dir=(1,1), speed=3, frame -> (0,0), dir=(0,0), hit=1 and hit_corner=1 for one cycle.
REQ-038 btn_pause_n toggles 3 times within 3 cycles then holds low 10 cycles -> exactly one RUN->PAUSE transition; following frames leave the position unchanged.
REQ-039 Seven clean speed presses from speed=1 -> speed sequence 2,3,4,5,6,7,1.
REQ-040 Pause press accepted on the same cycle as frame_tick in RUN -> position advances once, then running=0.

Source files
------------

// File: rtl/box_motion_ctrl.sv
// box_motion_ctrl: bouncing-box position controller, stepped once per frame in vertical blanking,
// with debounced pause/resume and speed-step buttons.
module box_motion_ctrl #(
    parameter int SCREEN_W     = 800,
    parameter int SCREEN_H     = 480,
    parameter int BOX_W        = 70,
    parameter int BOX_H        = 70,
    parameter int DEBOUNCE_CYC = 250000,
    parameter int SPEED_MAX    = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       btn_pause_n,
    input  logic       btn_speed_n,
    output logic [9:0] box_x,
    output logic [8:0] box_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic [2:0] speed,
    output logic       running,
    output logic       hit,
    output logic       hit_corner
);
    localparam int            CW       = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic [9:0]    X_MAX    = 10'(SCREEN_W - BOX_W);
    localparam logic [8:0]    Y_MAX    = 9'(SCREEN_H - BOX_H);

    typedef enum logic [1:0] {INIT, RUN, PAUSE} state_t;

    state_t        r_state;
    logic [2:0]    r_vs;
    logic [1:0]    r_btn_s1, r_btn_s2, r_btn_acc, r_btn_acc_d;
    logic [CW-1:0] r_deb_cnt [2];
    logic [9:0]    r_box_x;
    logic [8:0]    r_box_y;
    logic          r_dir_x, r_dir_y, r_running, r_hit, r_hit_corner;
    logic [2:0]    r_speed;

    logic          w_tick, w_x_hit, w_y_hit;
    logic [1:0]    w_press;
    logic [10:0]   w_x_sum;
    logic [9:0]    w_y_sum, w_x_next;
    logic [8:0]    w_y_next;
    state_t        w_state_next;

    // Bit 0 of the button vectors is pause, bit 1 is speed.
    always_comb begin
        w_tick       = r_vs[1] & ~r_vs[2];
        w_press      = r_btn_acc_d & ~r_btn_acc;
        w_x_sum      = {1'b0, r_box_x} + 11'(r_speed);
        w_y_sum      = {1'b0, r_box_y} + 10'(r_speed);
        w_x_hit      = r_dir_x ? (r_box_x <= 10'(r_speed)) : (w_x_sum >= {1'b0, X_MAX});
        w_y_hit      = r_dir_y ? (r_box_y <= 9'(r_speed)) : (w_y_sum >= {1'b0, Y_MAX});
        w_x_next     = r_dir_x ? (w_x_hit ? 10'd0 : r_box_x - 10'(r_speed)) : (w_x_hit ? X_MAX : w_x_sum[9:0]);
        w_y_next     = r_dir_y ? (w_y_hit ? 9'd0 : r_box_y - 9'(r_speed)) : (w_y_hit ? Y_MAX : w_y_sum[8:0]);
        w_state_next = (r_state == INIT) ? (w_tick ? RUN : INIT) :
                       !w_press[0]       ? r_state :
                       (r_state == RUN)  ? PAUSE : RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vs         <= '1;
            r_btn_s1     <= '1;
            r_btn_s2     <= '1;
            r_btn_acc    <= '1;
            r_btn_acc_d  <= '1;
            r_deb_cnt[0] <= '0;
            r_deb_cnt[1] <= '0;
            r_state      <= INIT;
            r_box_x      <= 10'd2;
            r_box_y      <= 9'd2;
            r_dir_x      <= 1'b0;
            r_dir_y      <= 1'b0;
            r_speed      <= 3'd1;
            r_running    <= 1'b0;
            r_hit        <= 1'b0;
            r_hit_corner <= 1'b0;
        end else begin
            r_vs        <= {r_vs[1:0], vsync};
            r_btn_s1    <= {btn_speed_n, btn_pause_n};
            r_btn_s2    <= r_btn_s1;
            r_btn_acc_d <= r_btn_acc;
            for (int i = 0; i < 2; i++) begin
                if (r_btn_s2[i] == r_btn_acc[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == CNT_LAST) begin
                    r_btn_acc[i] <= r_btn_s2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + CW'(1);
                end
            end
            r_state      <= w_state_next;
            r_running    <= (w_state_next == RUN);
            r_hit        <= 1'b0;
            r_hit_corner <= 1'b0;
            // Position step always uses the pre-edge state and speed.
            if (w_tick && r_state == RUN) begin
                r_box_x      <= w_x_next;
                r_box_y      <= w_y_next;
                r_dir_x      <= r_dir_x ^ w_x_hit;
                r_dir_y      <= r_dir_y ^ w_y_hit;
                r_hit        <= w_x_hit | w_y_hit;
                r_hit_corner <= w_x_hit & w_y_hit;
            end
            if (w_press[1])
                r_speed <= (r_speed == 3'(SPEED_MAX)) ? 3'd1 : r_speed + 3'd1;
        end
    end

    assign box_x      = r_box_x;
    assign box_y      = r_box_y;
    assign dir_x      = r_dir_x;
    assign dir_y      = r_dir_y;
    assign speed      = r_speed;
    assign running    = r_running;
    assign hit        = r_hit;
    assign hit_corner = r_hit_corner;
endmodule
